// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI-attached byte RAM.
// Provides command encodings and default geometry.
package spi_ram_pkg;

    localparam int MEM_DEPTH_DEF = 256;
    localparam int ADDR_SIZE_DEF = 8;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_ram_slave.sv
// Byte RAM behind an SPI slave front end; executes 2-bit commands.
// Ports: clk, rst_n (sync, active-low), Din[9:0] = {cmd, payload},
//        rx_valid, Dout[7:0] read data, tx_valid one-cycle read strobe.
module spi_ram_slave
    import spi_ram_pkg::*;
#(
    parameter int MEM_DEPTH = MEM_DEPTH_DEF,
    parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] Din,
    input  logic       rx_valid,
    output logic [7:0] Dout,
    output logic       tx_valid
);

    logic [7:0] mem [MEM_DEPTH];

    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] rd_addr;

    logic [1:0]           cmd;
    logic [7:0]           payload;
    logic                 wa_en;
    logic                 wd_en;
    logic                 ra_en;
    logic                 rd_en;

    assign cmd     = Din[9:8];
    assign payload = Din[7:0];

    always_comb begin
        wa_en = 1'b0;
        wd_en = 1'b0;
        ra_en = 1'b0;
        rd_en = 1'b0;
        if (rst_n && rx_valid) begin
            unique case (cmd)
                CMD_WR_ADDR: wa_en = 1'b1;
                CMD_WR_DATA: wd_en = 1'b1;
                CMD_RD_ADDR: ra_en = 1'b1;
                CMD_RD_DATA: rd_en = 1'b1;
                default:     ;
            endcase
        end
    end

    // Storage has no reset so preloaded contents survive rst_n.
    // wd_en already excludes reset cycles.
    always_ff @(posedge clk) begin
        if (wd_en) begin
            mem[wr_addr] <= payload;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_addr  <= '0;
            rd_addr  <= '0;
            Dout     <= '0;
            tx_valid <= 1'b0;
        end else begin
            // Strobe tracks only this cycle's accepted read.
            tx_valid <= rd_en;
            if (wa_en) wr_addr <= payload[ADDR_SIZE-1:0];
            if (ra_en) rd_addr <= payload[ADDR_SIZE-1:0];
            if (rd_en) Dout    <= mem[rd_addr];
        end
    end

endmodule

// File: tb/tb_spi_ram_slave.sv
// Self-checking bench for spi_ram_slave.
// Vector table plus random traffic checked against a read scoreboard.
module tb_spi_ram_slave;

    logic       clk;
    logic       rst_n;
    logic [9:0] Din;
    logic       rx_valid;
    logic [7:0] Dout;
    logic       tx_valid;

    int tests;
    int fails;

    logic [7:0] mmem [256];
    logic [7:0] m_wa;
    logic [7:0] m_ra;
    logic [7:0] m_dout;
    logic       m_tx;
    logic [7:0] sb_q [$];

    spi_ram_slave dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .Din      (Din),
        .rx_valid (rx_valid),
        .Dout     (Dout),
        .tx_valid (tx_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       rxv;
        logic [1:0] cmd;
        logic [7:0] data;
        logic [7:0] exp_dout;
        logic       exp_tx;
    } vec_t;

    vec_t vecs [29];

    function automatic logic [7:0] pre(input int i);
        logic [7:0] v;
        v = 8'(i);
        return v ^ 8'h3C;
    endfunction

    task automatic check8(input string name, input logic [7:0] act,
                          input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act,
                          input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Drive one cycle, update the model, then check after the edge.
    task automatic step(input logic rst, input logic rxv,
                        input logic [1:0] cmd, input logic [7:0] data);
        @(negedge clk);
        rst_n    = rst;
        rx_valid = rxv;
        Din      = {cmd, data};
        if (!rst) begin
            m_wa   = 8'h00;
            m_ra   = 8'h00;
            m_dout = 8'h00;
            m_tx   = 1'b0;
        end else begin
            m_tx = 1'b0;
            if (rxv) begin
                case (cmd)
                    2'b00: m_wa = data;
                    2'b01: mmem[m_wa] = data;
                    2'b10: m_ra = data;
                    default: begin
                        m_dout = mmem[m_ra];
                        m_tx   = 1'b1;
                        sb_q.push_back(mmem[m_ra]);
                    end
                endcase
            end
        end
        @(posedge clk);
        #1;
        check1("tx_model", tx_valid, m_tx);
        check8("dout_model", Dout, m_dout);
        if (tx_valid === 1'b1) begin
            tests++;
            if (sb_q.size() == 0) begin
                fails++;
                $display("FAIL sb_empty: got tx_valid=1 expected no read");
            end else begin
                check8("sb_read", Dout, sb_q.pop_front());
            end
        end
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        rst_n    = 1'b1;
        rx_valid = 1'b0;
        Din      = '0;
        for (int i = 0; i < 256; i++) begin
            mmem[i]    = pre(i);
            dut.mem[i] = pre(i);
        end
        m_wa   = 8'h00;
        m_ra   = 8'h00;
        m_dout = 8'h00;
        m_tx   = 1'b0;

        vecs[0]  = '{1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 2'b10, 8'hFE, 8'h00, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 2'b11, 8'h00, 8'hC2, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 2'b00, 8'h00, 8'hC2, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 2'b00, 8'hFE, 8'hC2, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 2'b01, 8'hA5, 8'hC2, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 2'b10, 8'hFE, 8'hC2, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 2'b11, 8'h00, 8'hA5, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 2'b00, 8'h00, 8'hA5, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 2'b00, 8'h03, 8'hA5, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 2'b01, 8'h11, 8'hA5, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 2'b01, 8'h22, 8'hA5, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 2'b10, 8'h03, 8'hA5, 1'b0};
        vecs[14] = '{1'b1, 1'b1, 2'b11, 8'h00, 8'h22, 1'b1};
        vecs[15] = '{1'b1, 1'b1, 2'b11, 8'h9C, 8'h22, 1'b1};
        vecs[16] = '{1'b1, 1'b0, 2'b01, 8'hFF, 8'h22, 1'b0};
        vecs[17] = '{1'b1, 1'b0, 2'b10, 8'h00, 8'h22, 1'b0};
        vecs[18] = '{1'b1, 1'b1, 2'b11, 8'h00, 8'h22, 1'b1};
        vecs[19] = '{1'b1, 1'b1, 2'b00, 8'h0A, 8'h22, 1'b0};
        vecs[20] = '{1'b0, 1'b1, 2'b01, 8'h77, 8'h00, 1'b0};
        vecs[21] = '{1'b1, 1'b1, 2'b01, 8'h5A, 8'h00, 1'b0};
        vecs[22] = '{1'b1, 1'b1, 2'b10, 8'h00, 8'h00, 1'b0};
        vecs[23] = '{1'b1, 1'b1, 2'b11, 8'h00, 8'h5A, 1'b1};
        vecs[24] = '{1'b1, 1'b1, 2'b10, 8'h0A, 8'h5A, 1'b0};
        vecs[25] = '{1'b1, 1'b1, 2'b11, 8'h00, 8'h36, 1'b1};
        vecs[26] = '{1'b1, 1'b1, 2'b10, 8'hFE, 8'h36, 1'b0};
        vecs[27] = '{1'b1, 1'b1, 2'b11, 8'h00, 8'hA5, 1'b1};
        vecs[28] = '{1'b1, 1'b0, 2'b11, 8'h00, 8'hA5, 1'b0};

        for (int i = 0; i < 29; i++) begin
            step(vecs[i].rst, vecs[i].rxv, vecs[i].cmd, vecs[i].data);
            check8($sformatf("vec%0d_dout", i), Dout, vecs[i].exp_dout);
            check1($sformatf("vec%0d_tx", i), tx_valid, vecs[i].exp_tx);
        end

        // Read-after-write on consecutive cycles, corner addresses.
        step(1'b1, 1'b1, 2'b00, 8'hFF);
        step(1'b1, 1'b1, 2'b10, 8'hFF);
        step(1'b1, 1'b1, 2'b01, 8'hC3);
        step(1'b1, 1'b1, 2'b11, 8'h00);
        check8("raw_ff", Dout, 8'hC3);
        step(1'b1, 1'b1, 2'b01, 8'h3D);
        step(1'b1, 1'b1, 2'b11, 8'h00);
        check8("raw_ff_overwrite", Dout, 8'h3D);

        // Random traffic through the model and scoreboard.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 49) != 0),
                 ($urandom_range(0, 3) != 0),
                 2'($urandom_range(0, 3)),
                 8'($urandom_range(0, 255)));
        end

        step(1'b1, 1'b0, 2'b00, 8'h00);
        tests++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL sb_left: got %0d pending expected 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
